// File: rtl/stb_wr_pkg.sv
// Shared types, AXI constants and decode helpers for the STB AXI write engine.
package stb_wr_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_AW    = 3'd1;
  localparam state_t ST_WDAT  = 3'd2;
  localparam state_t ST_DRAIN = 3'd3;
  localparam state_t ST_RESP  = 3'd4;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_EXOKAY = 2'b01;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;
  localparam logic [1:0] BRESP_DECERR = 2'b11;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // Burst code 0..3 selects 1/2/4/8 beats.
  function automatic logic [3:0] brst_beats(input logic [1:0] code);
    brst_beats = 4'd1 << code;
  endfunction

  // Number of low byte lanes enabled by a byte-strobe code.
  function automatic int unsigned strb_bytes(input logic [3:0] code,
                                             input int unsigned byte_cnt);
    strb_bytes = (32'(code) + 32'd1) * byte_cnt / 32'd16;
  endfunction

  function automatic logic [3:0] lowest_lane(input logic [15:0] v);
    lowest_lane = '0;
    for (int unsigned i = 16; i > 0; i--) begin
      if (v[i-1]) lowest_lane = 4'(i - 1);
    end
  endfunction

endpackage

// File: rtl/stb_outst_tracker.sv
// Outstanding AW-burst counter with MAX_OUTST stall flag for the STB write engine.
module stb_outst_tracker #(
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic aw_hs,
  input  logic b_hs,
  output logic full,
  output logic busy
);

  logic [3:0] outst;
  logic       inc;
  logic       dec;

  assign busy = (outst != '0);
  assign full = (outst == 4'(MAX_OUTST));
  assign inc  = aw_hs;
  // A stray B with nothing outstanding must not underflow the count.
  assign dec  = b_hs && busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst <= '0;
    end else if (inc && !dec) begin
      outst <= outst + 4'd1;
    end else if (dec && !inc) begin
      outst <= outst - 4'd1;
    end
  end

endmodule

// File: rtl/stb_axi_wr_engine.sv
// STB store engine: streams UR data into per-lane AXI write bursts.
// Optional STB_WR_PERF_EN adds saturating beat and busy-cycle counters.
module stb_axi_wr_engine
  import stb_wr_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned SMC_COUNT  = 6,
  parameter int unsigned INTLV_STEP = 64,
  parameter int unsigned MAX_OUTST  = 4,
  parameter int unsigned UR_AW      = 11
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      stb_u_valid,
  output logic                      stb_u_ready,
  input  logic [SMC_COUNT-1:0]      stb_u_smc_strb,
  input  logic [3:0]                stb_u_byte_strb,
  input  logic [1:0]                stb_u_brst,
  input  logic [ADDR_WIDTH-1:0]     stb_u_gr_base_addr,
  input  logic [UR_AW-1:0]          stb_u_ur_addr,
  output logic                      ur_re,
  output logic [UR_AW-1:0]          ur_addr,
  input  logic [DATA_WIDTH-1:0]     ur_rdata,
  output logic                      awvalid,
  input  logic                      awready,
  output logic [ADDR_WIDTH-1:0]     awaddr,
  output logic [7:0]                awlen,
  output logic [2:0]                awsize,
  output logic [1:0]                awburst,
  output logic                      wvalid,
  input  logic                      wready,
  output logic [DATA_WIDTH-1:0]     wdata,
  output logic [DATA_WIDTH/8-1:0]   wstrb,
  output logic                      wlast,
  input  logic                      bvalid,
  output logic                      bready,
  input  logic [1:0]                bresp,
  output logic                      stb_d_valid,
  input  logic                      stb_d_ready,
  output logic                      stb_d_err,
  output logic [31:0]               perf_beats,
  output logic [31:0]               perf_busy
);

  localparam int unsigned BYTE_CNT = DATA_WIDTH / 8;
  localparam logic [2:0]  AW_SIZE  = 3'($clog2(BYTE_CNT));

  state_t                state;
  logic [SMC_COUNT-1:0]  lanes_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [3:0]            beats_q;
  logic [3:0]            beat_cnt;
  logic [UR_AW-1:0]      ur_ptr;
  logic                  rd_pend;
  logic [3:0]            cur_lane;
  logic [BYTE_CNT-1:0]   strb_mask;
  logic                  full;
  logic                  busy;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  b_hs;

  assign stb_u_ready = (state == ST_IDLE);
  assign awvalid     = (state == ST_AW) && !full;
  assign aw_hs       = awvalid && awready;
  assign w_hs        = wvalid && wready;
  assign bready      = busy;
  assign b_hs        = bvalid && bready;

  // lanes_q keeps only lanes not yet issued, so the lowest set bit is the current lane.
  assign cur_lane = lowest_lane(16'(lanes_q));
  assign awaddr   = base_q + ADDR_WIDTH'(32'(cur_lane) * INTLV_STEP);

  always_comb begin
    strb_mask = '0;
    for (int unsigned i = 0; i < BYTE_CNT; i++) begin
      strb_mask[i] = (i < strb_bytes(stb_u_byte_strb, BYTE_CNT));
    end
  end

  stb_outst_tracker #(.MAX_OUTST(MAX_OUTST)) u_outst (
    .clk   (clk),
    .rst_n (rst_n),
    .aw_hs (aw_hs),
    .b_hs  (b_hs),
    .full  (full),
    .busy  (busy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      lanes_q     <= '0;
      base_q      <= '0;
      beats_q     <= '0;
      beat_cnt    <= '0;
      ur_ptr      <= '0;
      ur_re       <= 1'b0;
      ur_addr     <= '0;
      rd_pend     <= 1'b0;
      awlen       <= '0;
      awsize      <= '0;
      awburst     <= '0;
      wvalid      <= 1'b0;
      wdata       <= '0;
      wstrb       <= '0;
      wlast       <= 1'b0;
      stb_d_valid <= 1'b0;
      stb_d_err   <= 1'b0;
    end else begin
      ur_re   <= 1'b0;
      rd_pend <= ur_re;
      if (b_hs && (bresp != BRESP_OKAY)) stb_d_err <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (stb_u_valid) begin
            stb_d_err <= 1'b0;
            lanes_q   <= stb_u_smc_strb;
            base_q    <= stb_u_gr_base_addr;
            beats_q   <= brst_beats(stb_u_brst);
            awlen     <= 8'(brst_beats(stb_u_brst) - 4'd1);
            awsize    <= AW_SIZE;
            awburst   <= AXI_BURST_INCR;
            wstrb     <= strb_mask;
            ur_ptr    <= stb_u_ur_addr;
            if (stb_u_smc_strb == '0) begin
              state       <= ST_RESP;
              stb_d_valid <= 1'b1;
            end else begin
              state <= ST_AW;
            end
          end
        end
        ST_AW: begin
          if (aw_hs) begin
            lanes_q  <= lanes_q & (lanes_q - SMC_COUNT'(1));
            beat_cnt <= '0;
            ur_re    <= 1'b1;
            ur_addr  <= ur_ptr;
            ur_ptr   <= ur_ptr + UR_AW'(1);
            state    <= ST_WDAT;
          end
        end
        ST_WDAT: begin
          // UR data lands one cycle after ur_re and is registered so W stays stable.
          if (rd_pend) begin
            wvalid <= 1'b1;
            wdata  <= ur_rdata;
            wlast  <= (beat_cnt == beats_q - 4'd1);
          end
          if (w_hs) begin
            wvalid   <= 1'b0;
            wlast    <= 1'b0;
            beat_cnt <= beat_cnt + 4'd1;
            if (wlast) begin
              state <= (lanes_q == '0) ? ST_DRAIN : ST_AW;
            end else begin
              ur_re   <= 1'b1;
              ur_addr <= ur_ptr;
              ur_ptr  <= ur_ptr + UR_AW'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (!busy) begin
            state       <= ST_RESP;
            stb_d_valid <= 1'b1;
          end
        end
        ST_RESP: begin
          if (stb_d_ready) begin
            stb_d_valid <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef STB_WR_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_beats <= '0;
      perf_busy  <= '0;
    end else begin
      if (w_hs && (perf_beats != '1)) perf_beats <= perf_beats + 32'd1;
      if ((state != ST_IDLE) && (perf_busy != '1)) perf_busy <= perf_busy + 32'd1;
    end
  end
`else
  assign perf_beats = '0;
  assign perf_busy  = '0;
`endif

endmodule

// File: doc/stb_axi_wr_engine.md
STB_AXI_WR_ENGINE -- requirements
Module: stb_axi_wr_engine

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 128, AXI/UR data width; BYTE_CNT = DATA_WIDTH/8, a multiple of 16.
REQ-003 SHALL have parameter SMC_COUNT, default 6, number of SMC lanes (1..16).
REQ-004 SHALL have parameter INTLV_STEP, default 64, byte address step between SMC lanes.
REQ-005 SHALL have parameter MAX_OUTST, default 4, maximum AW bursts awaiting B (1..15).
REQ-006 SHALL have parameter UR_AW, default 11, UR address width.
REQ-007 SHALL have ports, in this order: clk in 1 clock; rst_n in 1 asynchronous active-low reset; stb_u_valid in 1 instruction valid; stb_u_ready out 1 instruction accept; stb_u_smc_strb in SMC_COUNT lane enables; stb_u_byte_strb in 4 byte-enable code; stb_u_brst in 2 burst code; stb_u_gr_base_addr in ADDR_WIDTH base address; stb_u_ur_addr in UR_AW UR start address; ur_re out 1 UR read; ur_addr out UR_AW UR read address; ur_rdata in DATA_WIDTH UR data; AXI AW group (awvalid, awready, awaddr, awlen[8], awsize[3], awburst[2]); W group (wvalid, wready, wdata, wstrb[BYTE_CNT], wlast); B group (bvalid, bready, bresp[2]); stb_d_valid out 1 completion valid; stb_d_ready in 1 completion accept; stb_d_err out 1 any non-OKAY bresp; perf_beats out 32; perf_busy out 32.

Function
REQ-008 SHALL assert stb_u_ready only in IDLE; instruction is captured on stb_u_valid && stb_u_ready.
REQ-009 SHALL decode stb_u_brst 00/01/10/11 to 1/2/4/8 beats; awlen = beats-1; awsize = log2(BYTE_CNT); awburst = 2'b01.
REQ-010 SHALL drive wstrb with the low (code+1)*BYTE_CNT/16 bits set, all others clear, for every beat.
REQ-011 SHALL issue one burst per set bit of smc_strb, in ascending lane index, awaddr = base + lane*INTLV_STEP (ADDR_WIDTH modulo).
REQ-012 SHALL fetch UR data sequentially from stb_u_ur_addr, +1 per beat across all bursts, wrapping modulo 2^UR_AW.
REQ-013 SHALL treat UR read latency as exactly 1 cycle: ur_re at cycle t, ur_rdata sampled at t+1.
REQ-014 SHALL use states IDLE -> AW -> WDAT -> (AW for next lane | DRAIN) -> RESP -> IDLE.
REQ-015 SHALL hold awvalid and AW fields stable until awready; enter WDAT only after AW handshake.
REQ-016 SHALL hold wvalid/wdata/wstrb stable until wready; wlast on final beat only; ur_re issues the next read only after the current beat handshakes.
REQ-017 SHALL stall in AW (awvalid low) while outstanding count equals MAX_OUTST; outstanding +1 on AW handshake, -1 on B handshake, both same cycle -> unchanged.
REQ-018 SHALL keep bready high whenever outstanding > 0.
REQ-019 SHALL in DRAIN wait for outstanding == 0, then enter RESP.
REQ-020 SHALL in RESP hold stb_d_valid high until stb_d_ready; stb_d_err is the sticky OR of (bresp != 2'b00) over the instruction, cleared on capture.
REQ-021 SHALL, when smc_strb == 0, go IDLE -> RESP in one cycle with stb_d_err = 0 and no AXI/UR traffic.
REQ-022 SHALL ignore stb_u_valid outside IDLE; any B handshake while outstanding == 0 is ignored.

Reset
REQ-023 SHALL on rst_n low, immediately and regardless of state: state IDLE, outstanding 0, every valid/ur_re/bready/stb_d_valid/stb_d_err low, all address/data outputs 0, perf counters 0; in-flight bursts are abandoned.

Configuration
REQ-024 SHALL, with STB_WR_PERF_EN defined, count perf_beats (+1 per W handshake) and perf_busy (+1 per cycle not in IDLE), both saturating at 2^32-1.
REQ-025 SHALL, without STB_WR_PERF_EN, tie perf_beats and perf_busy to 0 and contain no counter logic.

Structure
REQ-026 SHALL take the state enum, BRESP constants and brst/byte-strobe decode functions from shared package stb_wr_pkg.
REQ-027 SHALL place the outstanding counter and the MAX_OUTST stall flag in sub-module stb_outst_tracker.

Verification
REQ-028 smc_strb=6'b000101, brst=01, base=0x1000, ur_addr=0 -> AW 0x1000 then 0x1080, awlen=1 each, UR addrs 0,1,2,3.
REQ-029 byte_strb=4'd3, DATA_WIDTH=128 -> wstrb=16'h000F on every beat.
REQ-030 ur_addr=0x7FF, brst=10, one lane -> UR addrs 0x7FF,0x000,0x001,0x002.
REQ-031 MAX_OUTST=2, all 6 lanes, bvalid held low -> exactly 2 AW handshakes, then awvalid low until a B handshake.
REQ-032 one bresp=2'b10 among 3 bursts -> stb_d_err=1; stb_d_valid held until stb_d_ready pulse.
REQ-033 rst_n low mid-WDAT -> next cycle all outputs 0, stb_u_ready high after release; smc_strb=0 -> stb_d_valid one cycle after capture.
